// File: rtl/frame_slot_scheduler_pkg.sv
// Shared types and 50 MHz defaults for the per-frame resource slot scheduler.
package frame_slot_scheduler_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ARB        = 2'd1,
    GRANT      = 2'd2,
    CLOSED     = 2'd3
  } state_t;

  // 16 ms frame at 50 MHz
  localparam int DEF_FRAME_LEN = 800000;
  localparam int DEF_GUARD     = 2048;
  localparam int DEF_HOLD_MAX  = 4096;
  localparam int DEF_CNT_W     = 20;
  localparam int ERR_IDX_W     = 3;

endpackage

// File: rtl/frame_slot_scheduler_rr_pick.sv
// Combinational round-robin picker: first pending index at or after ptr, wrapping.
module frame_slot_scheduler_rr_pick
  import frame_slot_scheduler_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]     pending,
  input  logic [ERR_IDX_W-1:0] ptr,
  output logic                 valid,
  output logic [ERR_IDX_W-1:0] idx,
  output logic [N_REQ-1:0]     onehot
);

  // Rotate so the search always starts at bit 0, then map back to an absolute index
  always_comb begin
    logic [N_REQ-1:0] rot;
    int sel;
    rot    = N_REQ'({pending, pending} >> ptr);
    sel    = 0;
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        sel   = int'(ptr) + k;
        if (sel >= N_REQ) sel = sel - N_REQ;
        idx    = ERR_IDX_W'(sel);
        onehot = {{(N_REQ-1){1'b0}}, 1'b1} << sel;
      end
    end
  end

endmodule

// File: rtl/frame_slot_scheduler.sv
// Per-frame round-robin slot scheduler: one service per requester per control frame,
// with hold timeout, closing guard window and frame-end abort of a running grant.
module frame_slot_scheduler
  import frame_slot_scheduler_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int GUARD     = DEF_GUARD,
  parameter int HOLD_MAX  = DEF_HOLD_MAX,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_tick,
  input  logic                 frame_clr,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     done,
  output logic [N_REQ-1:0]     grant,
  output logic                 frame_active,
  output logic                 window_open,
  output logic                 timeout_err,
  output logic                 overrun_err,
  output logic [ERR_IDX_W-1:0] err_idx,
  output logic [N_REQ-1:0]     served
);

  localparam logic [CNT_W-1:0]     FRAME_END = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]     WIN_END   = CNT_W'(FRAME_LEN - GUARD);
  localparam logic [CNT_W-1:0]     HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [ERR_IDX_W-1:0] LAST_IDX  = ERR_IDX_W'(N_REQ - 1);

  state_t               state;
  logic                 tick_q;
  logic [CNT_W-1:0]     frame_cnt;
  logic [CNT_W-1:0]     hold_cnt;
  logic [N_REQ-1:0]     grant_q;
  logic [ERR_IDX_W-1:0] gidx;
  logic [ERR_IDX_W-1:0] rr_ptr;
  logic [ERR_IDX_W-1:0] next_ptr;
  logic [N_REQ-1:0]     pending;
  logic [N_REQ-1:0]     pick_onehot;
  logic [ERR_IDX_W-1:0] pick_idx;
  logic                 pick_valid;
  logic                 frame_edge;
  logic                 done_hit;

  assign frame_edge  = frame_tick & ~tick_q;
  assign pending     = req & ~served;
  assign done_hit    = |(done & grant_q);
  assign next_ptr    = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
  assign window_open = frame_active && (frame_cnt < WIN_END);
  // frame_clr takes the resource away in the same cycle, ahead of the registered drop
  assign grant       = grant_q & {N_REQ{~frame_clr}};

  frame_slot_scheduler_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .pending (pending),
    .ptr     (rr_ptr),
    .valid   (pick_valid),
    .idx     (pick_idx),
    .onehot  (pick_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_FRAME;
      tick_q       <= 1'b0;
      frame_cnt    <= '0;
      hold_cnt     <= '0;
      grant_q      <= '0;
      gidx         <= '0;
      rr_ptr       <= '0;
      frame_active <= 1'b0;
      timeout_err  <= 1'b0;
      overrun_err  <= 1'b0;
      err_idx      <= '0;
      served       <= '0;
    end else begin
      tick_q      <= frame_tick;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
      if (frame_active && frame_cnt != FRAME_END) frame_cnt <= frame_cnt + 1'b1;

      // Frame end, or a new frame start that arrives before the old frame was cleared
      if (frame_active && (frame_clr || frame_edge)) begin
        grant_q <= '0;
        if (state == GRANT) begin
          overrun_err <= 1'b1;
          err_idx     <= gidx;
          rr_ptr      <= next_ptr;
          served      <= served | grant_q;
        end
        if (frame_edge) begin
          served    <= '0;
          frame_cnt <= '0;
          state     <= ARB;
        end else begin
          frame_active <= 1'b0;
          state        <= WAIT_FRAME;
        end
      end else begin
        unique case (state)
          WAIT_FRAME: begin
            if (frame_edge) begin
              served       <= '0;
              frame_cnt    <= '0;
              frame_active <= 1'b1;
              state        <= ARB;
            end
          end
          ARB: begin
            if (!window_open) begin
              state <= CLOSED;
            end else if (pick_valid) begin
              grant_q  <= pick_onehot;
              gidx     <= pick_idx;
              hold_cnt <= '0;
              state    <= GRANT;
            end
          end
          GRANT: begin
            hold_cnt <= hold_cnt + 1'b1;
            // A completion in the final hold cycle still counts as a clean finish
            if (done_hit || hold_cnt == HOLD_LAST) begin
              grant_q <= '0;
              served  <= served | grant_q;
              rr_ptr  <= next_ptr;
              state   <= ARB;
              if (!done_hit) begin
                timeout_err <= 1'b1;
                err_idx     <= gidx;
              end
            end
          end
          CLOSED: begin
          end
          default: state <= WAIT_FRAME;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_slot_scheduler.sv
// Directed plus randomized bench for frame_slot_scheduler with a set/modulo reference model.
module tb_frame_slot_scheduler;

  localparam int N       = 4;
  localparam int FLEN    = 8192;
  localparam int GRD     = 1024;
  localparam int HMAX    = 4096;
  localparam int WIN_END = FLEN - GRD;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         frame_tick;
  logic         frame_clr;
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] grant;
  logic         frame_active;
  logic         window_open;
  logic         timeout_err;
  logic         overrun_err;
  logic [2:0]   err_idx;
  logic [N-1:0] served;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] m_req;
  logic [N-1:0] m_served;
  int           m_ptr;
  int           m_err;

  frame_slot_scheduler #(
    .N_REQ(N), .FRAME_LEN(FLEN), .GUARD(GRD), .HOLD_MAX(HMAX), .CNT_W(20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .frame_clr    (frame_clr),
    .req          (req),
    .done         (done),
    .grant        (grant),
    .frame_active (frame_active),
    .window_open  (window_open),
    .timeout_err  (timeout_err),
    .overrun_err  (overrun_err),
    .err_idx      (err_idx),
    .served       (served)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r);
    m_req = r;
    req   = r;
  endtask

  // Who should win next: first unserved requester at or after the pointer, wrapping
  function automatic int model_pick();
    logic [N-1:0] p;
    p = m_req & ~m_served;
    for (int k = 0; k < N; k++)
      if (p[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic start_frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    m_served = '0;
    checkOutput("start_active", frame_active, 1);
    checkOutput("start_served", served, 0);
    checkOutput("start_window", window_open, 1);
  endtask

  task automatic end_frame(input int g);
    frame_clr = 1'b1;
    #1;
    checkOutput("clr_grant_mask", grant, 0);
    step();
    frame_clr = 1'b0;
    if (g >= 0) begin
      m_served = m_served | N'(1 << g);
      m_err    = g;
      m_ptr    = (g + 1) % N;
    end
    checkOutput("end_overrun", overrun_err, (g >= 0) ? 1 : 0);
    checkOutput("end_active", frame_active, 0);
    checkOutput("end_window", window_open, 0);
    checkOutput("end_served", served, m_served);
    checkOutput("end_err_idx", err_idx, m_err);
    step();
    checkOutput("end_overrun_pulse", overrun_err, 0);
  endtask

  task automatic run_episode(input int hold, input logic [N-1:0] noise, input bit abort_mid);
    int idx;
    logic [N-1:0] bitv;
    idx  = model_pick();
    bitv = (idx >= 0) ? N'(1 << idx) : '0;
    step();
    checkOutput("grant_on", grant, bitv);
    checkOutput("timeout_idle", timeout_err, 0);
    checkOutput("overrun_idle", overrun_err, 0);
    for (int k = 0; k < hold; k++) begin
      done = noise & ~bitv;
      step();
      checkOutput("grant_hold", grant, bitv);
    end
    if (abort_mid) begin
      done = '0;
      end_frame(idx);
    end else begin
      done = bitv;
      step();
      done = '0;
      m_served = m_served | bitv;
      m_ptr    = (idx + 1) % N;
      applyStimulus(m_req & ~bitv);
      checkOutput("grant_off", grant, 0);
      checkOutput("done_no_timeout", timeout_err, 0);
      checkOutput("done_served", served, m_served);
    end
  endtask

  initial begin
    int cnt;
    bit aborted;
    rst_n = 1'b1; frame_tick = 1'b0; frame_clr = 1'b0; req = '0; done = '0;
    m_req = '0; m_served = '0; m_ptr = 0; m_err = 0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_active", frame_active, 0);
    checkOutput("rst_window", window_open, 0);
    checkOutput("rst_timeout", timeout_err, 0);
    checkOutput("rst_overrun", overrun_err, 0);
    checkOutput("rst_err_idx", err_idx, 0);
    checkOutput("rst_served", served, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // Basic frame, immediate completions: 0, 1, 3
    applyStimulus(4'b1011);
    start_frame();
    for (int e = 0; e < 3; e++) run_episode(0, 4'b0000, 0);
    checkOutput("basic_served", served, 4'b1011);
    checkOutput("basic_timeout", timeout_err, 0);
    end_frame(-1);

    // Pointer persists across frames: serve 2, then 3,0,1,2
    applyStimulus(4'b0100);
    start_frame();
    run_episode(0, 4'b0000, 0);
    end_frame(-1);
    applyStimulus(4'b1111);
    start_frame();
    for (int e = 0; e < 4; e++) run_episode(1, 4'b0000, 0);
    checkOutput("rr_served", served, 4'b1111);
    end_frame(-1);

    // Hold timeout on requester 1, then requester 2 follows
    applyStimulus(4'b0110);
    start_frame();
    step();
    checkOutput("to_grant", grant, 4'b0010);
    cnt = 1;
    while (grant == 4'b0010 && cnt < HMAX + 8) begin
      step();
      if (grant == 4'b0010) cnt++;
    end
    m_served = m_served | 4'b0010; m_ptr = 2; m_err = 1;
    checkOutput("to_hold_cycles", cnt, HMAX);
    checkOutput("to_pulse", timeout_err, 1);
    checkOutput("to_err_idx", err_idx, 1);
    checkOutput("to_served", served, m_served);
    run_episode(0, 4'b0000, 0);
    end_frame(-1);

    // Completion in the last hold cycle beats the timeout
    applyStimulus(4'b1000);
    start_frame();
    run_episode(HMAX - 1, 4'b0101, 0);
    checkOutput("edge_done_err_idx", err_idx, 1);
    end_frame(-1);

    // Guard window closes the frame to new grants
    applyStimulus(4'b0000);
    start_frame();
    repeat (WIN_END - 1) step();
    checkOutput("guard_open_last", window_open, 1);
    step();
    checkOutput("guard_closed", window_open, 0);
    applyStimulus(4'b0001);
    repeat (4) step();
    checkOutput("guard_no_grant", grant, 0);
    checkOutput("guard_still_active", frame_active, 1);
    end_frame(-1);
    start_frame();
    run_episode(0, 4'b0000, 0);
    end_frame(-1);

    // frame_clr during grant[2]
    applyStimulus(4'b0100);
    start_frame();
    run_episode(2, 4'b1011, 1);

    // New frame start while a grant runs
    applyStimulus(4'b1001);
    start_frame();
    step();
    checkOutput("miss_grant", grant, 4'b1000);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    m_err = 3; m_ptr = 0; m_served = '0;
    checkOutput("miss_overrun", overrun_err, 1);
    checkOutput("miss_err_idx", err_idx, 3);
    checkOutput("miss_served", served, 0);
    checkOutput("miss_active", frame_active, 1);
    checkOutput("miss_grant_drop", grant, 0);
    run_episode(0, 4'b0000, 0);
    run_episode(0, 4'b0000, 0);
    end_frame(-1);

    // Asynchronous reset mid-grant
    applyStimulus(4'b0010);
    start_frame();
    step();
    checkOutput("rst_mid_grant_on", grant, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_grant", grant, 0);
    checkOutput("rst_mid_active", frame_active, 0);
    checkOutput("rst_mid_err_idx", err_idx, 0);
    #1 rst_n = 1'b1;
    m_ptr = 0; m_served = '0; m_err = 0;
    step();
    for (int k = 0; k < 8; k++) begin
      step();
      checkOutput("rst_post_no_grant", grant, 0);
    end
    start_frame();
    run_episode(0, 4'b0000, 0);
    end_frame(-1);

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      applyStimulus(N'($urandom_range(1, 15)));
      start_frame();
      aborted = 0;
      while (!aborted && model_pick() >= 0) begin
        aborted = ($urandom_range(0, 5) == 0);
        run_episode($urandom_range(0, 4), N'($urandom), aborted);
      end
      if (!aborted) end_frame(-1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_slot_scheduler.md
Name: frame_slot_scheduler

Overview:
- Shares one resource (e.g. motor-driver SPI / ADC sequencer) among N_REQ requesters, once per 16 ms control frame.
- Frame boundaries come from the periodic frame timer outputs: frame_tick rises at frame start, frame_clr marks the frame end.
- Round-robin grants, one service per requester per frame, per-grant hold timeout, closing guard window before frame end.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- FRAME_LEN, 800000, nominal frame length in clk cycles (16 ms at 50 MHz)
- GUARD, 2048, cycles before FRAME_LEN after which no new grant is issued
- HOLD_MAX, 4096, maximum cycles a grant may be held
- CNT_W, 20, width of frame and hold counters (must hold FRAME_LEN)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- frame_tick  in  1  level from frame timer; rising edge = frame start
- frame_clr  in  1  level from frame timer; high = frame end / abort
- req  in  N_REQ  per-requester service request, level, held until granted
- done  in  N_REQ  per-requester completion pulse, valid only while that grant is high
- grant  out  N_REQ  one-hot (or zero) grant
- frame_active  out  1  high from frame start until frame end
- window_open  out  1  frame_active and frame count < FRAME_LEN-GUARD
- timeout_err  out  1  one-cycle pulse, grant revoked by HOLD_MAX
- overrun_err  out  1  one-cycle pulse, grant revoked by frame_clr
- err_idx  out  3  index of requester in last error; holds until next error
- served  out  N_REQ  requesters served this frame; cleared at frame start

Behaviour:
- Reset: grant=0, frame_active=0, window_open=0, timeout_err=0, overrun_err=0, err_idx=0, served=0, rr pointer=0, counters=0, state WAIT_FRAME.
- frame_tick is registered once. Rising edge = frame_tick high, previous sample low; detected one cycle after the input edge.
- States:
  - WAIT_FRAME: on edge -> ARB; served cleared, frame_cnt=0, frame_active=1.
  - ARB: if window open and any req & ~served, grant the first such index at or after rr_ptr (wrapping); drive grant next cycle; -> GRANT. If the window is closed -> CLOSED. Otherwise stay.
  - GRANT: hold_cnt increments from 0.
    - done[g] -> grant=0, served[g]=1, rr_ptr=g+1 mod N_REQ, -> ARB.
    - hold_cnt==HOLD_MAX-1 with no done -> revoke, timeout_err pulse, err_idx=g, served[g]=1, rr_ptr advances, -> ARB.
  - CLOSED: no new grants; wait for frame end.
- frame_cnt increments every cycle while frame_active and saturates at FRAME_LEN.
- Grant latency: min 1 cycle from ARB with pending req. Back-to-back grants have one idle cycle (ARB) between them.
- done on a non-granted bit is ignored. done and timeout in the same cycle: done wins, no error.
- Frame end is frame_clr high in any state except WAIT_FRAME:
  - Any active grant is dropped that cycle.
  - If a grant was active: overrun_err pulse, err_idx=g, served[g]=1, rr_ptr advances.
  - frame_active=0 -> WAIT_FRAME. served keeps its value until the next frame start.
- Frame start edge while frame_active (missed clr) is treated as frame end then frame start in the same cycle:
  - overrun rules apply, then served is cleared.
- A frame with no frame_clr is still closed by the guard window: frame_cnt reaching FRAME_LEN-GUARD closes the window.
- Mid-operation reset aborts everything asynchronously; grant=0 immediately.
- Requesters never granted in a frame stay pending; no starvation, since rr_ptr persists across frames.

Decomposition:
- Shared package: state encoding (WAIT_FRAME, ARB, GRANT, CLOSED), FRAME_LEN/GUARD defaults for 50 MHz, err_idx width constant.
- One natural sub-module: rr_pick, a combinational round-robin priority picker (inputs req&~served, rr_ptr; outputs valid, index).

Test Plan:
- Frame edge with req=4'b1011, immediate done each grant -> grants in order idx0, idx1, idx3, one per grant episode; served=4'b1011; no errors.
- rr persistence: frame 1 serves only idx2 (rr_ptr=3); frame 2 with req=4'b1111 -> grant order 3,0,1,2.
- Timeout: req[1] held, no done -> grant[1] for exactly 4096 cycles; timeout_err pulses once; err_idx=1; served[1]=1; next requester granted.
- Guard: req[0] raised at frame_cnt=FRAME_LEN-GUARD -> no grant, window_open=0; grant[0] issued in the next frame.
- frame_clr while grant[2] high -> grant drops that cycle; overrun_err pulse; err_idx=2; frame_active=0.
- Assert rst_n low during GRANT -> grant=0 asynchronously; after release, no grant until the next frame_tick rising edge.
